// File: rtl/steer_en_pkg.sv
// Shared segway definitions: steering FSM states, rider weight threshold
// and enable-timer widths.
`timescale 1ns/1ps
package steer_en_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  localparam logic [12:0] MIN_RIDER_WT_DEF = 13'h200;

  localparam int TMR_W      = 26;
  localparam int TMR_W_FAST = 15;

endpackage

// File: rtl/steer_tmr.sv
// Balanced-rider hold timer: free-running up-counter with synchronous clear
// and a terminal-count flag whose width shrinks under FAST_SIM.
`timescale 1ns/1ps
module steer_tmr
  import steer_en_pkg::*;
#(
  parameter logic FAST_SIM = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_tmr,
  output logic tmr_full
);

  logic [TMR_W-1:0] cnt;

  // No saturation: the FSM leaves WAIT on the same cycle tmr_full is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (clr_tmr) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  assign tmr_full = FAST_SIM ? (&cnt[TMR_W_FAST-1:0]) : (&cnt);

endmodule

// File: rtl/steer_en.sv
// Rider-presence / steering-enable controller: grants en_steer after a timed
// balanced stance, revokes it on gross imbalance or step-off.
`timescale 1ns/1ps
module steer_en
  import steer_en_pkg::*;
#(
  parameter logic        FAST_SIM     = 1'b0,
  parameter logic [12:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off
);

  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [11:0] lft_p0, rght_p0;
  logic [12:0] sum_p0;
  logic [11:0] diff_p0;
  logic        sum_gt_min, diff_gt_1_4, diff_gt_15_16;
  logic        clr_tmr, tmr_full;
  state_t      state;

  // Stage p0: load samples, held between ld_vld strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_p0  <= '0;
      rght_p0 <= '0;
    end else if (ld_vld) begin
      lft_p0  <= lft_ld;
      rght_p0 <= rght_ld;
    end
  end

  assign sum_p0        = {1'b0, lft_p0} + {1'b0, rght_p0};
  assign diff_p0       = abs_diff(lft_p0, rght_p0);
  assign sum_gt_min    = sum_p0 > MIN_RIDER_WT;
  assign diff_gt_1_4   = {1'b0, diff_p0} > (sum_p0 >> 2);
  assign diff_gt_15_16 = {1'b0, diff_p0} > (sum_p0 - (sum_p0 >> 4));

  // Timer restarts on WAIT entry and on every unbalanced cycle while waiting.
  always_comb begin
    clr_tmr = 1'b0;
    case (state)
      IDLE:    clr_tmr = sum_gt_min;
      WAIT:    clr_tmr = sum_gt_min && diff_gt_1_4;
      STEER:   clr_tmr = sum_gt_min && diff_gt_15_16;
      default: clr_tmr = 1'b0;
    endcase
  end

  steer_tmr #(.FAST_SIM(FAST_SIM)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_tmr  (clr_tmr),
    .tmr_full (tmr_full)
  );

  // Stage p1: FSM with registered outputs; step-off outranks imbalance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      en_steer  <= 1'b0;
      rider_off <= 1'b0;
    end else begin
      en_steer  <= (state == STEER);
      rider_off <= 1'b0;
      case (state)
        IDLE: begin
          if (sum_gt_min) state <= WAIT;
        end
        WAIT: begin
          if (!sum_gt_min) begin
            state     <= IDLE;
            rider_off <= 1'b1;
          end else if (!diff_gt_1_4 && tmr_full) begin
            state <= STEER;
          end
        end
        STEER: begin
          if (!sum_gt_min) begin
            state     <= IDLE;
            rider_off <= 1'b1;
          end else if (diff_gt_15_16) begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
